// File: rtl/accum_ctrl.sv
// accum_ctrl: sequencer for the accumulator columns below the systolic array.
// Clears the columns at job start, produces systolically skewed per-column
// write enables/addresses while result rows stream in across K passes, then
// drains the finished matrix as a valid/ready stream of column reads.
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   start, cfg_*            job request and its shape (rows, column tiles, passes)
//   busy, done              job in progress / one-cycle end-of-job pulse
//   in_valid, in_ready      column-0 result row handshake from the array
//   acc_clear               clear to every column
//   acc_wr_en, acc_wr_addr  per-column write enable and address (skewed)
//   acc_rd_en, acc_rd_addr  shared read enable and address
//   out_valid, out_ready    drain stream handshake; out_last marks final row
module accum_ctrl #(
    parameter int unsigned MAX_OUT_ROWS = 128,
    parameter int unsigned MAX_OUT_COLS = 128,
    parameter int unsigned SYS_ARR_COLS = 16,
    parameter int unsigned MAX_PASSES   = 256,
    localparam int unsigned TILES_MAX   = MAX_OUT_COLS / SYS_ARR_COLS,
    localparam int unsigned ADDR_W      = $clog2(MAX_OUT_ROWS * TILES_MAX),
    localparam int unsigned ROWS_W      = $clog2(MAX_OUT_ROWS + 1),
    localparam int unsigned TILES_W     = $clog2(TILES_MAX + 1),
    localparam int unsigned PASSES_W    = $clog2(MAX_PASSES + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ROWS_W-1:0]              cfg_rows,
    input  logic [TILES_W-1:0]             cfg_col_tiles,
    input  logic [PASSES_W-1:0]            cfg_passes,
    output logic                           busy,
    output logic                           done,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           acc_clear,
    output logic [SYS_ARR_COLS-1:0]        acc_wr_en,
    output logic [SYS_ARR_COLS*ADDR_W-1:0] acc_wr_addr,
    output logic                           acc_rd_en,
    output logic [ADDR_W-1:0]              acc_rd_addr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last
);

    localparam int unsigned FLUSH_W    = (SYS_ARR_COLS > 2) ? $clog2(SYS_ARR_COLS - 1) : 1;
    localparam int unsigned FLUSH_LAST = (SYS_ARR_COLS > 1) ? SYS_ARR_COLS - 2 : 0;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ACCUM, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ROWS_W-1:0]    rows_q, rows_d, row_q, row_d;
    logic [TILES_W-1:0]   tiles_q, tiles_d, tile_q, tile_d;
    logic [PASSES_W-1:0]  passes_q, passes_d, pass_q, pass_d;
    logic [FLUSH_W-1:0]   flush_q, flush_d;
    logic                 rd_done_q, rd_done_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;

    logic [ROWS_W-1:0]    rows_sat;
    logic [TILES_W-1:0]   tiles_sat;
    logic [PASSES_W-1:0]  passes_sat;
    logic                 cfg_zero;
    logic                 last_row, last_tile, last_pass, last_rd;
    logic                 beat, last_beat, rd_go, final_accept;
    logic [ADDR_W-1:0]    cur_addr;

    // Saturate requested shape to the supported maximum
    assign rows_sat   = (cfg_rows > ROWS_W'(MAX_OUT_ROWS)) ? ROWS_W'(MAX_OUT_ROWS) : cfg_rows;
    assign tiles_sat  = (cfg_col_tiles > TILES_W'(TILES_MAX)) ? TILES_W'(TILES_MAX) : cfg_col_tiles;
    assign passes_sat = (cfg_passes > PASSES_W'(MAX_PASSES)) ? PASSES_W'(MAX_PASSES) : cfg_passes;
    assign cfg_zero   = (rows_sat == '0) | (tiles_sat == '0) | (passes_sat == '0);

    assign last_row  = (row_q == rows_q - ROWS_W'(1));
    assign last_tile = (tile_q == tiles_q - TILES_W'(1));
    assign last_pass = (pass_q == passes_q - PASSES_W'(1));
    assign last_rd   = last_row & last_tile;

    // Row/tile counters serve both the write walk (ACCUM) and the read walk (DRAIN)
    assign cur_addr     = ADDR_W'(tile_q) * ADDR_W'(MAX_OUT_ROWS) + ADDR_W'(row_q);
    assign beat         = (state_q == S_ACCUM) & in_valid;
    assign last_beat    = beat & last_rd & last_pass;
    assign rd_go        = (state_q == S_DRAIN) & ~rd_done_q & (~out_valid_q | out_ready);
    assign final_accept = (state_q == S_DRAIN) & out_valid_q & out_ready & out_last_q;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = cfg_zero ? S_DONE : S_CLEAR;
            S_CLEAR: state_d = S_ACCUM;
            S_ACCUM: if (last_beat) state_d = (SYS_ARR_COLS > 1) ? S_FLUSH : S_DRAIN;
            S_FLUSH: if (flush_q == FLUSH_W'(FLUSH_LAST)) state_d = S_DRAIN;
            S_DRAIN: if (final_accept) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        in_ready    = 1'b0;
        acc_clear   = 1'b0;
        acc_rd_en   = 1'b0;
        acc_rd_addr = '0;
        case (state_q)
            S_CLEAR: begin busy = 1'b1; acc_clear = 1'b1; end
            S_ACCUM: begin busy = 1'b1; in_ready = 1'b1; end
            S_FLUSH: busy = 1'b1;
            S_DRAIN: begin busy = 1'b1; acc_rd_en = rd_go; acc_rd_addr = cur_addr; end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Counter and drain-stream next values
    always_comb begin
        rows_d      = rows_q;
        tiles_d     = tiles_q;
        passes_d    = passes_q;
        row_d       = row_q;
        tile_d      = tile_q;
        pass_d      = pass_q;
        flush_d     = flush_q;
        rd_done_d   = rd_done_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if ((state_q == S_IDLE) && start) begin
            rows_d      = rows_sat;
            tiles_d     = tiles_sat;
            passes_d    = passes_sat;
            row_d       = '0;
            tile_d      = '0;
            pass_d      = '0;
            flush_d     = '0;
            rd_done_d   = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (beat | rd_go) begin
            row_d = last_row ? '0 : row_q + ROWS_W'(1);
            if (last_row) tile_d = last_tile ? '0 : tile_q + TILES_W'(1);
            if (beat & last_rd) pass_d = last_pass ? '0 : pass_q + PASSES_W'(1);
        end
        if (state_q == S_FLUSH) flush_d = flush_q + FLUSH_W'(1);
        // A new read refills the output slot; otherwise an accept empties it
        if (rd_go) begin
            rd_done_d   = last_rd;
            out_valid_d = 1'b1;
            out_last_d  = last_rd;
        end else if ((state_q == S_DRAIN) && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rows_q      <= '0;
            tiles_q     <= '0;
            passes_q    <= '0;
            row_q       <= '0;
            tile_q      <= '0;
            pass_q      <= '0;
            flush_q     <= '0;
            rd_done_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            rows_q      <= rows_d;
            tiles_q     <= tiles_d;
            passes_q    <= passes_d;
            row_q       <= row_d;
            tile_q      <= tile_d;
            pass_q      <= pass_d;
            flush_q     <= flush_d;
            rd_done_q   <= rd_done_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign acc_wr_addr[0 +: ADDR_W] = cur_addr;

    // Column c sees the column-0 write delayed by c cycles (systolic skew)
    if (SYS_ARR_COLS > 1) begin : g_skew
        logic [SYS_ARR_COLS-2:0] sr_en_q;
        logic [ADDR_W-1:0]       sr_addr_q [SYS_ARR_COLS-1];

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sr_en_q <= '0;
                for (int i = 0; i < int'(SYS_ARR_COLS) - 1; i++) sr_addr_q[i] <= '0;
            end else begin
                sr_en_q[0]   <= beat;
                sr_addr_q[0] <= cur_addr;
                for (int i = 1; i < int'(SYS_ARR_COLS) - 1; i++) begin
                    sr_en_q[i]   <= sr_en_q[i-1];
                    sr_addr_q[i] <= sr_addr_q[i-1];
                end
            end
        end

        assign acc_wr_en = {sr_en_q, beat};
        for (genvar c = 1; c < int'(SYS_ARR_COLS); c++) begin : g_addr
            assign acc_wr_addr[c*ADDR_W +: ADDR_W] = sr_addr_q[c-1];
        end
    end else begin : g_noskew
        assign acc_wr_en = beat;
    end

endmodule

// File: doc/accum_ctrl.md
# accum_ctrl

Sequencer for the bank of SYS_ARR_COLS accumCol accumulator columns that sit below the systolic array. It clears the columns at job start and generates skewed per-column write enables/addresses as result rows leave the array, accumulating across K passes. It then drains the finished matrix with a valid/ready stream, issuing reads and flagging the last beat. The output datapath itself (`rd_data` of each column) bypasses this block; only control passes through it.

## Interface
- MAX_OUT_ROWS, 128, largest output height
- MAX_OUT_COLS, 128, largest output width
- SYS_ARR_COLS, 16, systolic array width = number of accumCol instances
- MAX_PASSES, 256, largest accumulation pass count
- (local) ADDR_W = $clog2(MAX_OUT_ROWS*(MAX_OUT_COLS/SYS_ARR_COLS)); TILES_MAX = MAX_OUT_COLS/SYS_ARR_COLS

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  job request, sampled only in IDLE
- cfg_rows  in  $clog2(MAX_OUT_ROWS+1)  output rows per tile
- cfg_col_tiles  in  $clog2(TILES_MAX+1)  column tiles
- cfg_passes  in  $clog2(MAX_PASSES+1)  accumulation passes
- busy  out  1  high in CLEAR, ACCUM, FLUSH, DRAIN
- done  out  1  one-cycle pulse at job end
- in_valid  in  1  column-0 result row present at array output
- in_ready  out  1  high only in ACCUM
- acc_clear  out  1  to all columns' `clear`
- acc_wr_en  out  SYS_ARR_COLS  bit c to column c `wr_en`
- acc_wr_addr  out  SYS_ARR_COLS*ADDR_W  slice c to column c `wr_addr`
- acc_rd_en  out  1  to all columns' `rd_en`
- acc_rd_addr  out  ADDR_W  to all columns' `rd_addr`
- out_valid  out  1  column `rd_data` holds a valid row
- out_ready  in  1  consumer accepts row
- out_last  out  1  qualifies final out_valid beat

## Operation
- States: IDLE, CLEAR, ACCUM, FLUSH, DRAIN, DONE.
- IDLE: on start, latch cfg (each field saturated to its max). Any latched field = 0 -> DONE, with no clear/write/read. Else -> CLEAR. start outside IDLE is ignored.
- CLEAR: acc_clear=1 for exactly one cycle -> ACCUM.
- ACCUM: beat = in_valid & in_ready. Counters row (0..rows-1), tile (0..tiles-1), pass (0..passes-1), nested row innermost. They advance only on a beat.
- Beat address = tile*MAX_OUT_ROWS + row.
- acc_wr_en[0] = beat (combinational), and acc_wr_addr[0] = beat address.
- Column c>0 receives the column-0 enable/address delayed c cycles via a shift register; systolic skew.
- Last beat (final row, tile, pass) -> FLUSH; if SYS_ARR_COLS==1, -> DRAIN directly.
- FLUSH: SYS_ARR_COLS-1 cycles, letting the shift register empty. in_ready=0 -> DRAIN.
- DRAIN: read index walks tile-major (row inner), addr = tile*MAX_OUT_ROWS + row, for rows*tiles reads.
  - acc_rd_en=1 when reads remain and (!out_valid | out_ready).
  - out_valid sets the cycle after acc_rd_en and clears when accepted with no new read.
  - out_last=1 with the final beat.
  - Final beat accepted -> DONE.
- DONE: done=1 one cycle, busy=0 -> IDLE.
- Reads are never issued while any write is pending, so there is no read/write hazard.

## Timing
- Reset values: all outputs 0, state IDLE, counters and shift register 0. Accumulator memory is untouched.
- Reset mid-job aborts immediately. The next start re-clears.
- start at cycle t -> acc_clear at t+1 -> in_ready from t+2.
- Beat at cycle b -> acc_wr_en[c] at b+c.
- Last beat at L -> first acc_rd_en at L+SYS_ARR_COLS.
- acc_rd_en at r -> out_valid at r+1. Full throughput of 1 row/cycle when out_ready is held high.
- out_ready low: out_valid, out_last, acc_rd_addr held; acc_rd_en=0; no beat lost or duplicated.
- Final beat accepted at f -> done at f+1 -> IDLE at f+2.
- Zero-config start at t -> done at t+1.
- in_valid outside ACCUM is ignored. out_ready outside DRAIN is ignored.

## Test plan
- rows=2, tiles=1, passes=1, start @0 -> acc_clear @1; beats @2,3 -> wr_en[0] addr 0,1 @2,3 and wr_en[15] addr 0,1 @17,18; rd_en @19,20 addr 0,1; out_last @21; done @22.
- rows=3, tiles=2, passes=2 -> write address order 0,1,2,128,129,130 twice (12 beats); drain reads 0,1,2,128,129,130; out_last on 6th beat.
- Drain with out_ready low for 3 cycles on beat 2 -> out_valid stays high, rd_addr stable, rd_en=0; resumes with addr 2; exactly 6 beats total.
- in_valid gaps of 1-4 cycles between beats -> counters hold; each wr_en[c] lands exactly c cycles after its own beat.
- cfg_rows=0 -> done one cycle after start; acc_clear, wr_en, and rd_en never asserted.
- reset asserted mid-ACCUM -> all outputs 0 asynchronously, state IDLE; a subsequent start clears and runs the full sequence correctly.
